dmem_lsu_ram: RTL and testbench

- Parametrised successor to the core's fixed 16K x 32 single-port data RAM.
- Adds a valid/ready load/store request port and sub-word size handling: strobe generation, lane steering, sign/zero extension and misalignment detection.
- Adds a registered response channel with backpressure.
- Sits between the RISC-V LSU and an internally inferred single-port RAM array.

---
 rtl/dmem_lsu_ram.sv | 187 ++++++++++++++++++
 tb/tb_dmem_lsu_ram.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ram.sv
// dmem_lsu_ram: LSU-facing data RAM with a valid/ready request port, sub-word
// load/store formatting and a registered response channel with backpressure.
// Stores write in the accept cycle; loads read in the accept cycle and are
// formatted from the registered RAM output one cycle later.
// Optional macro DMEM_LSU_OUTREG_EN: adds output stage S2 holding the formatted
// response (latency 2, still one access per cycle).
module dmem_lsu_ram #(
  parameter int    ADDR_WIDTH = 14,
  parameter int    DATA_WIDTH = 32,
  parameter int    BE_WIDTH   = DATA_WIDTH / 8,
  parameter int    OFF_WIDTH  = $clog2(BE_WIDTH),
  parameter string INIT_FILE  = "NONE"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [ADDR_WIDTH+OFF_WIDTH-1:0] req_addr,
  input  logic [1:0]                      req_size,
  input  logic                            req_unsigned,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BA_WIDTH = ADDR_WIDTH + OFF_WIDTH;

  // RAM array and its registered read port (contents are never reset)
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] ram_q_reg;

  // Request decode
  logic [OFF_WIDTH-1:0]  req_off;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [3:0]            req_nbytes;
  logic                  req_err;
  logic                  accept;
  logic                  ram_en;
  logic                  s1_advance;
  logic [BE_WIDTH-1:0]   strobe;
  logic [DATA_WIDTH-1:0] wdata_shifted;

  // Stage S1: request attributes of the access whose data is in ram_q_reg
  logic                  s1_valid_reg;
  logic                  s1_we_reg;
  logic [OFF_WIDTH-1:0]  s1_off_reg;
  logic [1:0]            s1_size_reg;
  logic                  s1_unsigned_reg;
  logic                  s1_err_reg;

  // Load formatting
  logic [DATA_WIDTH-1:0] shifted_q;
  logic [3:0]            s1_nbytes;
  logic                  sign_bit;
  logic                  fill_bit;
  logic [DATA_WIDTH-1:0] fmt_lanes;
  logic [DATA_WIDTH-1:0] fmt_rdata;
  logic                  fmt_err;

  assign req_off       = req_addr[OFF_WIDTH-1:0];
  assign req_word      = req_addr[BA_WIDTH-1:OFF_WIDTH];
  assign req_nbytes    = 4'd1 << req_size;
  assign accept        = req_valid && req_ready;
  assign ram_en        = accept && !req_err;
  assign wdata_shifted = req_wdata << {req_off, 3'b000};

  // Alignment / legality check: dword only exists on a 64-bit RAM
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      default: req_err = (DATA_WIDTH == 32) || (|req_addr[2:0]);
    endcase
  end

  // Byte strobes: lanes [offset, offset + size_bytes) are written
  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_strobe
      assign strobe[gi] = (gi >= int'(req_off)) &&
                          (gi < int'(req_off) + int'(req_nbytes));
    end
  endgenerate

  // Single-port RAM: byte-strobed write or registered read, never both
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (req_we) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (strobe[i]) begin
            mem[req_word][8*i +: 8] <= wdata_shifted[8*i +: 8];
          end
        end
      end else begin
        ram_q_reg <= mem[req_word];
      end
    end
  end

  // S1 capture on accept; empties when its response moves on without refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_we_reg       <= 1'b0;
      s1_off_reg      <= '0;
      s1_size_reg     <= 2'd0;
      s1_unsigned_reg <= 1'b0;
      s1_err_reg      <= 1'b0;
    end else if (accept) begin
      s1_valid_reg    <= 1'b1;
      s1_we_reg       <= req_we;
      s1_off_reg      <= req_off;
      s1_size_reg     <= req_size;
      s1_unsigned_reg <= req_unsigned;
      s1_err_reg      <= req_err;
    end else if (s1_advance) begin
      s1_valid_reg    <= 1'b0;
    end
  end

  assign shifted_q = ram_q_reg >> {s1_off_reg, 3'b000};
  assign s1_nbytes = 4'd1 << s1_size_reg;
  assign fill_bit  = sign_bit && !s1_unsigned_reg;

  // Pick the operand's top bit for sign extension
  always_comb begin
    sign_bit = 1'b0;
    case (s1_size_reg)
      2'd0:    sign_bit = shifted_q[7];
      2'd1:    sign_bit = shifted_q[15];
      2'd2:    sign_bit = shifted_q[31];
      default: sign_bit = shifted_q[DATA_WIDTH-1];
    endcase
  end

  // Keep the operand's lanes, fill the rest with the extension bit
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_fmt
      assign fmt_lanes[8*gi +: 8] = (gi < int'(s1_nbytes)) ? shifted_q[8*gi +: 8]
                                                            : {8{fill_bit}};
    end
  endgenerate

  // Stores and erroneous accesses return zero data
  assign fmt_rdata = (s1_valid_reg && !s1_we_reg && !s1_err_reg) ? fmt_lanes : '0;
  assign fmt_err   = s1_valid_reg && s1_err_reg;

`ifdef DMEM_LSU_OUTREG_EN
  logic                  s2_valid_reg;
  logic                  s2_err_reg;
  logic [DATA_WIDTH-1:0] s2_rdata_reg;

  assign s1_advance = !s2_valid_reg || rsp_ready;

  // S2 takes the formatted S1 response whenever it is empty or being drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_rdata_reg <= '0;
    end else if (s1_advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_err_reg   <= fmt_err;
      s2_rdata_reg <= fmt_rdata;
    end
  end

  assign rsp_valid = s2_valid_reg;
  assign rsp_rdata = s2_rdata_reg;
  assign rsp_err   = s2_err_reg;
`else
  assign s1_advance = rsp_ready;
  assign rsp_valid  = s1_valid_reg;
  assign rsp_rdata  = fmt_rdata;
  assign rsp_err    = fmt_err;
`endif

  // S1 is free when empty or when its content leaves this cycle
  assign req_ready = !s1_valid_reg || s1_advance;

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// tb_dmem_lsu_ram: directed vector table plus randomized traffic checked
// against a byte-array memory model and an in-order response queue.
module tb_dmem_lsu_ram;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int BW = AW + OW;
`ifdef DMEM_LSU_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [63:0] DMASK = {64{1'b1}} >> (64 - DW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [BW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  dmem_lsu_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic          we;
    logic [BW-1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  logic [7:0]  mref [int];
  exp_t        expq [$];
  vec_t        vecs [16];

  int          checks = 0;
  int          errors = 0;
  int          nrsp = 0;
  logic        last_stall = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [63:0] pop_rdata = '0;
  logic        pop_err = 1'b0;
  int          pop_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian operands, natural alignment
  function automatic exp_t model_op(input logic we, input int a, input int sz,
                                    input logic uns, input logic [63:0] wd);
    exp_t e;
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    e.err = ((sz == 3) && (DW == 32)) || ((a % n) != 0);
    e.rdata = '0;
    e.acc_cyc = 0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mref[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mref[a + i];
        if (!uns && n < 8 && v[8*n - 1]) begin
          for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // One clock cycle: drive, check handshake/response against the model, book-keep
  task automatic step(input logic v, input logic we, input logic [BW-1:0] a,
                      input logic [1:0] sz, input logic uns, input logic [DW-1:0] wd,
                      input logic rr, output logic acc);
    logic exp_valid;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd; rsp_ready = rr;
    #1;
    exp_valid = (expq.size() > 0) && ((cyc - expq[0].acc_cyc) >= LAT);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    chk("req_ready", 64'(req_ready), 64'((expq.size() < LAT) || rr));
    if (last_stall) begin
      chk("hold_rdata", 64'(rsp_rdata), 64'(last_rdata));
      chk("hold_err", 64'(rsp_err), 64'(last_err));
    end
    if (rsp_valid && exp_valid && rr) begin
      e = expq.pop_front();
      chk("rsp_rdata", 64'(rsp_rdata), e.rdata & DMASK);
      chk("rsp_err", 64'(rsp_err), 64'(e.err));
      pop_rdata = 64'(rsp_rdata);
      pop_err = rsp_err;
      pop_lat = cyc - e.acc_cyc;
      nrsp++;
      $display("rsp %0d: rdata=%h err=%0b latency=%0d", nrsp, rsp_rdata, rsp_err, pop_lat);
    end
    acc = v && req_ready;
    if (acc) begin
      e = model_op(we, int'(a), int'(sz), uns, 64'(wd));
      e.acc_cyc = cyc;
      expq.push_back(e);
    end
    last_stall = rsp_valid && !rr;
    last_rdata = rsp_rdata;
    last_err = rsp_err;
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && expq.size() > 0; k++) step(1'b0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b1, acc);
    chk("drain_left", 64'(expq.size()), 64'd0);
  endtask

  // Isolated access with its own latency and data checks
  task automatic do_op(input vec_t t, input int idx);
    logic acc;
    int n0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) step(1'b1, t.we, t.addr, t.size, t.uns, t.wdata, 1'b1, acc);
    chk($sformatf("vec%0d_accept", idx), 64'(acc), 64'd1);
    n0 = nrsp;
    for (int k = 0; k < 10 && nrsp == n0; k++) step(1'b0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b1, acc);
    chk($sformatf("vec%0d_responses", idx), 64'(nrsp - n0), 64'd1);
    chk($sformatf("vec%0d_rdata", idx), pop_rdata, 64'(t.exp_rdata));
    chk($sformatf("vec%0d_err", idx), 64'(pop_err), 64'(t.exp_err));
    chk($sformatf("vec%0d_latency", idx), 64'(pop_lat), 64'(LAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    logic acc;
    int n0;
    int k;

    //           we    addr        size  uns   wdata          exp_rdata      exp_err
    vecs[0]  = '{1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 2'd2, 1'b1, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 16'h0013, 2'd0, 1'b0, 32'h00000080, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 16'h0013, 2'd0, 1'b0, 32'h00000000, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 16'h0013, 2'd0, 1'b1, 32'h00000000, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 16'h0010, 2'd2, 1'b1, 32'h00000000, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 16'h0011, 2'd1, 1'b1, 32'h00000000, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b1, 16'h0012, 2'd2, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, 16'h0010, 2'd2, 1'b1, 32'h00000000, 32'h80ADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 16'h0012, 2'd1, 1'b0, 32'h00000000, 32'hFFFF80AD, 1'b0};
    vecs[10] = '{1'b0, 16'h0010, 2'd1, 1'b1, 32'h00000000, 32'h0000BEEF, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFF, 2'd0, 1'b0, 32'h000000A5, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 16'hFFFF, 2'd0, 1'b0, 32'h00000000, 32'hFFFFFFA5, 1'b0};
    vecs[13] = '{1'b0, 16'h0010, 2'd3, 1'b1, 32'h00000000, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 16'h0016, 2'd1, 1'b0, 32'hFFFF1234, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, 16'h0016, 2'd1, 1'b0, 32'h00000000, 32'h00001234, 1'b0};

    // Reset state
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 16; i++) do_op(vecs[i], i);

    // Fill a 256-byte region so random loads only see known data
    for (int w = 0; w < 64; w++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++)
        step(1'b1, 1'b1, BW'(32'h100 + 4*w), 2'd2, 1'b0, DW'($urandom), 1'b1, acc);
      chk("fill_accept", 64'(acc), 64'd1);
    end
    drain();

    // Stream of 8 loads with a 3-cycle consumer stall in the middle
    n0 = nrsp;
    k = 0;
    for (int i = 0; i < 8 && k < 40; ) begin
      step(1'b1, 1'b0, BW'(32'h100 + 4*i), 2'd2, 1'b1, '0, !(k >= 3 && k <= 5), acc);
      if (acc) i++;
      k++;
    end
    drain();
    chk("stream_responses", 64'(nrsp - n0), 64'd8);

    // Asynchronous reset while a response is pending
    step(1'b1, 1'b0, BW'(32'h104), 2'd2, 1'b1, '0, 1'b0, acc);
    for (int t = 0; t < LAT; t++) step(1'b0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("async_rst_rsp_err", 64'(rsp_err), 64'd0);
    expq.delete();
    last_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // Random traffic with random backpressure in the filled region
    for (int t = 0; t < 500; t++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 2,
           BW'(32'h100 + $urandom_range(0, 255)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
